// File: rtl/tile_router.sv
// Mesh tile router: one transmit FSM that hands a tile word to a single
// neighbour link, and one receive FIFO per link drained by the tile through
// a round-robin arbiter. The transmit and receive paths share no state.
//
// Transmit FSM
//   state | meaning
//   IDLE  | waiting for the tile to raise send
//   BUSY  | offering the latched word on link tx_dest until it acknowledges
//   DONE  | one-cycle send_done pulse, then back to IDLE
module tile_router #(
  parameter int DATA_W     = 32,
  parameter int NPORTS     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [DATA_W-1:0]        send_data,
  input  logic [2:0]               send_dest,
  input  logic                     send,
  output logic                     send_done,
  output logic [DATA_W-1:0]        recv_data,
  output logic [2:0]               recv_src,
  input  logic                     recv,
  output logic                     recv_valid,
  output logic                     bad_dest,
  output logic [NPORTS*DATA_W-1:0] link_send_data,
  output logic [NPORTS-1:0]        link_send_ready,
  input  logic [NPORTS-1:0]        link_send_done,
  input  logic [NPORTS*DATA_W-1:0] link_recv_data,
  input  logic [NPORTS-1:0]        link_recv_valid,
  output logic [NPORTS-1:0]        link_recv_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  NPORTS_W = 4'(NPORTS);
  localparam logic [PW-1:0] LAST_PORT = PW'(NPORTS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] tx_word;
  logic [2:0]        tx_dest;
  logic              dest_bad;
  logic              tx_ack;

  // Destinations beyond the last real link are rejected without touching any link.
  assign dest_bad  = ({1'b0, send_dest} >= NPORTS_W);
  assign send_done = (state == ST_DONE);

  // Only the acknowledge of the link we are actually driving can end the transfer.
  always_comb begin
    tx_ack = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (tx_dest == 3'(p)) tx_ack = link_send_done[p];
    end
  end

  // Transmit FSM with latched word/destination and the sticky bad_dest flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      tx_word  <= '0;
      tx_dest  <= '0;
      bad_dest <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (send) begin
            tx_word <= send_data;
            tx_dest <= send_dest;
            if (dest_bad) begin
              bad_dest <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: if (tx_ack) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Drive exactly one link while BUSY; all links are quiet and zeroed otherwise.
  always_comb begin
    link_send_ready = '0;
    link_send_data  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (state == ST_BUSY && tx_dest == 3'(p)) begin
        link_send_ready[p]                   = 1'b1;
        link_send_data[p*DATA_W +: DATA_W]   = tx_word;
      end
    end
  end

  logic [DATA_W-1:0] mem    [NPORTS][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr [NPORTS];
  logic [AW-1:0]     rd_ptr [NPORTS];
  logic [AW:0]       count  [NPORTS];
  logic [AW:0]       cnt_nxt[NPORTS];
  logic [NPORTS-1:0] push;
  logic [NPORTS-1:0] pop;
  logic [NPORTS-1:0] nonempty;
  logic [PW-1:0]     prio;
  logic [PW-1:0]     grant;
  logic              found;
  int                idx;

  assign push       = link_recv_valid & link_recv_ready;
  assign recv_valid = |nonempty;
  assign recv_src   = 3'(grant);
  assign recv_data  = recv_valid ? mem[grant][rd_ptr[grant]] : '0;

  // Per-FIFO occupancy view and next occupancy; push and pop together leave it unchanged.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      nonempty[p] = (count[p] != '0);
      pop[p]      = recv && recv_valid && (grant == PW'(p));
      case ({push[p], pop[p]})
        2'b10:   cnt_nxt[p] = count[p] + (AW+1)'(1);
        2'b01:   cnt_nxt[p] = count[p] - (AW+1)'(1);
        default: cnt_nxt[p] = count[p];
      endcase
    end
  end

  // Round-robin: first non-empty FIFO scanning upward from the priority pointer.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = int'(prio) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = PW'(idx);
      end
    end
  end

  // FIFO pointers, occupancy, registered ready and the arbiter priority pointer.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int p = 0; p < NPORTS; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end
      link_recv_ready <= '1;
      prio            <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
        count[p]           <= cnt_nxt[p];
        link_recv_ready[p] <= (cnt_nxt[p] != FULL_CNT);
      end
      if (recv && recv_valid) begin
        prio <= (grant == LAST_PORT) ? '0 : grant + PW'(1);
      end
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= link_recv_data[p*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_tile_router.sv
// Directed bench for tile_router: expected received words are queued when
// the stimulus drives them and compared when the tile pops them.
module tb_tile_router;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int FD = 4;

  typedef struct packed {
    logic [2:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk;
  logic              nrst;
  logic [DW-1:0]     send_data;
  logic [2:0]        send_dest;
  logic              send;
  logic              send_done;
  logic [DW-1:0]     recv_data;
  logic [2:0]        recv_src;
  logic              recv;
  logic              recv_valid;
  logic              bad_dest;
  logic [NP*DW-1:0]  link_send_data;
  logic [NP-1:0]     link_send_ready;
  logic [NP-1:0]     link_send_done;
  logic [NP*DW-1:0]  link_recv_data;
  logic [NP-1:0]     link_recv_valid;
  logic [NP-1:0]     link_recv_ready;

  int   n_checks;
  int   n_err;
  exp_t exp_q[$];

  tile_router #(.DATA_W(DW), .NPORTS(NP), .FIFO_DEPTH(FD)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .send_data       (send_data),
    .send_dest       (send_dest),
    .send            (send),
    .send_done       (send_done),
    .recv_data       (recv_data),
    .recv_src        (recv_src),
    .recv            (recv),
    .recv_valid      (recv_valid),
    .bad_dest        (bad_dest),
    .link_send_data  (link_send_data),
    .link_send_ready (link_send_ready),
    .link_send_done  (link_send_done),
    .link_recv_data  (link_recv_data),
    .link_recv_valid (link_recv_valid),
    .link_recv_ready (link_recv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word on link p for a cycle; acc says whether it must be accepted.
  task automatic push_link(input int p, input logic [DW-1:0] d, input logic acc);
    exp_t e;
    link_recv_data[p*DW +: DW] = d;
    link_recv_valid[p] = 1'b1;
    chk($sformatf("recv_ready%0d", p), DW'(link_recv_ready[p]), DW'(acc));
    if (acc) begin
      e.src  = 3'(p);
      e.data = d;
      exp_q.push_back(e);
    end
    step();
    link_recv_valid[p] = 1'b0;
  endtask

  // Compare the presented word against the scoreboard head, then pop it.
  task automatic pop_one(input string tag);
    exp_t e;
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s_queue: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, DW'(recv_valid), DW'(1));
      chk({tag, "_src"},   DW'(recv_src),   DW'(e.src));
      chk({tag, "_data"},  recv_data,       e.data);
    end
    recv = 1'b1;
    step();
  endtask

  initial begin
    exp_t e;
    n_checks = 0;
    n_err    = 0;
    nrst = 1'b0;
    send_data = '0; send_dest = '0; send = 1'b0; recv = 1'b0;
    link_send_done = '0; link_recv_data = '0; link_recv_valid = '0;
    step();
    step();
    chk("rst_send_done",  DW'(send_done),       '0);
    chk("rst_recv_valid", DW'(recv_valid),      '0);
    chk("rst_send_ready", DW'(link_send_ready), '0);
    chk("rst_send_data",  link_send_data[DW-1:0], '0);
    chk("rst_bad_dest",   DW'(bad_dest),        '0);
    nrst = 1'b1;
    chk("rel_recv_ready", DW'(link_recv_ready), DW'(4'hF));
    step();

    // One word on every link at once: served 0,1,2,3 with recv held high.
    link_recv_valid = 4'hF;
    for (int p = 0; p < NP; p++) begin
      link_recv_data[p*DW +: DW] = 32'h2000 + p;
      e.src = 3'(p); e.data = 32'h2000 + p;
      exp_q.push_back(e);
    end
    chk("all_ready", DW'(link_recv_ready), DW'(4'hF));
    step();
    link_recv_valid = '0;
    for (int p = 0; p < NP; p++) pop_one($sformatf("rr_%0d", p));
    recv = 1'b0;
    chk("rr_empty", DW'(recv_valid), '0);

    // Pop from link 2 moves priority to 3, so a 0/3 pair is served 3 first.
    push_link(2, 32'h2222, 1'b1);
    pop_one("rr_l2");
    recv = 1'b0;
    link_recv_data[0*DW +: DW] = 32'h3000;
    link_recv_data[3*DW +: DW] = 32'h3003;
    link_recv_valid = 4'b1001;
    e.src = 3'd3; e.data = 32'h3003; exp_q.push_back(e);
    e.src = 3'd0; e.data = 32'h3000; exp_q.push_back(e);
    step();
    link_recv_valid = '0;
    pop_one("pair_first");
    pop_one("pair_second");
    recv = 1'b0;

    // Normal transmit to link 2, acknowledged one cycle after ready.
    send_data = 32'hA5A5A5A5; send_dest = 3'd2; send = 1'b1;
    step();
    send = 1'b0;
    chk("tx_ready",     DW'(link_send_ready), DW'(4'b0100));
    chk("tx_data2",     link_send_data[2*DW +: DW], 32'hA5A5A5A5);
    chk("tx_done_early", DW'(send_done), '0);
    link_send_done = 4'b0100;
    step();
    link_send_done = '0;
    chk("tx_done",       DW'(send_done),       DW'(1));
    chk("tx_done_ready", DW'(link_send_ready), '0);
    step();
    chk("tx_done_pulse", DW'(send_done), '0);

    // Foreign acknowledges are ignored; held send restarts only from IDLE.
    send_data = 32'h1234_5678; send_dest = 3'd1; send = 1'b1;
    step();
    link_send_done = 4'b1101;
    chk("tx1_ready", DW'(link_send_ready), DW'(4'b0010));
    step();
    chk("tx1_ignore", DW'(link_send_ready), DW'(4'b0010));
    link_send_done = 4'b0010;
    step();
    link_send_done = '0;
    chk("tx1_done", DW'(send_done), DW'(1));
    step();
    chk("tx1_idle_ready", DW'(link_send_ready), '0);
    chk("tx1_idle_done",  DW'(send_done), '0);
    step();
    send = 1'b0;
    chk("tx1_restart", DW'(link_send_ready), DW'(4'b0010));
    link_send_done = 4'b0010;
    step();
    link_send_done = '0;
    chk("tx1_restart_done", DW'(send_done), DW'(1));
    step();

    // Illegal destination: no link offered, immediate done, sticky flag.
    send_dest = 3'd5; send = 1'b1;
    step();
    send = 1'b0;
    chk("bad_done",  DW'(send_done), DW'(1));
    chk("bad_ready", DW'(link_send_ready), '0);
    chk("bad_flag",  DW'(bad_dest), DW'(1));
    step();
    chk("bad_done_end", DW'(send_done), '0);
    chk("bad_sticky",   DW'(bad_dest), DW'(1));

    // Fill link 1; the fifth word must be refused, then drain in order.
    for (int i = 0; i < 5; i++) push_link(1, 32'h1000 + i, (i < 4));
    for (int i = 0; i < 4; i++) pop_one($sformatf("fill_%0d", i));
    recv = 1'b0;
    chk("fill_empty", DW'(recv_valid), '0);
    chk("fill_ready", DW'(link_recv_ready[1]), DW'(1));

    // Full FIFO 0 with a pending word: refused while full, accepted alongside the next pop.
    for (int i = 0; i < 4; i++) push_link(0, 32'h4000 + i, 1'b1);
    chk("full_ready", DW'(link_recv_ready[0]), '0);
    link_recv_data[0*DW +: DW] = 32'h4004;
    link_recv_valid[0] = 1'b1;
    pop_one("full_pop0");
    chk("full_ready_back", DW'(link_recv_ready[0]), DW'(1));
    e.src = 3'd0; e.data = 32'h4004; exp_q.push_back(e);
    pop_one("full_pop1");
    link_recv_valid[0] = 1'b0;
    chk("full_ready_kept", DW'(link_recv_ready[0]), DW'(1));
    for (int i = 2; i < 5; i++) pop_one($sformatf("full_pop%0d", i));
    recv = 1'b0;
    chk("full_empty", DW'(recv_valid), '0);

    // Single-word FIFO with simultaneous push and pop keeps the new word.
    push_link(0, 32'h4100, 1'b1);
    link_recv_data[0*DW +: DW] = 32'h4101;
    link_recv_valid[0] = 1'b1;
    e.src = 3'd0; e.data = 32'h4101; exp_q.push_back(e);
    pop_one("one_pop0");
    recv = 1'b0;
    link_recv_valid[0] = 1'b0;
    pop_one("one_pop1");
    recv = 1'b0;
    chk("one_empty", DW'(recv_valid), '0);

    // Reset during BUSY with two words waiting in FIFO 0.
    push_link(0, 32'h5000, 1'b1);
    push_link(0, 32'h5001, 1'b1);
    send_data = 32'hDEAD_BEEF; send_dest = 3'd0; send = 1'b1;
    step();
    send = 1'b0;
    chk("mid_busy", DW'(link_send_ready), DW'(4'b0001));
    nrst = 1'b0;
    step();
    exp_q.delete();
    chk("mid_rst_ready", DW'(link_send_ready), '0);
    chk("mid_rst_valid", DW'(recv_valid), '0);
    chk("mid_rst_done",  DW'(send_done), '0);
    chk("mid_rst_data",  link_send_data[DW-1:0], '0);
    nrst = 1'b1;
    chk("mid_rel_rready", DW'(link_recv_ready), DW'(4'hF));
    chk("mid_rel_bad",    DW'(bad_dest), '0);
    step();
    chk("mid_rel_done",  DW'(send_done), '0);
    chk("mid_rel_ready", DW'(link_send_ready), '0);
    chk("mid_rel_valid", DW'(recv_valid), '0);

    // Priority pointer back at 0: a 0/3 pair is now served 0 first.
    link_recv_data[0*DW +: DW] = 32'h6000;
    link_recv_data[3*DW +: DW] = 32'h6003;
    link_recv_valid = 4'b1001;
    e.src = 3'd0; e.data = 32'h6000; exp_q.push_back(e);
    e.src = 3'd3; e.data = 32'h6003; exp_q.push_back(e);
    step();
    link_recv_valid = '0;
    pop_one("post_rst_first");
    pop_one("post_rst_second");
    recv = 1'b0;
    chk("post_rst_empty", DW'(recv_valid), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
